fetch_controller: RTL and testbench

Sequences instruction fetch from a byte-wide instruction memory and presents 32-bit little-endian instructions to decode through a valid/ready handshake. The block owns the program counter. It issues one byte address per cycle and assembles four bytes into one instruction. It accepts branch redirects from execute and signals completion when the program runs past the end of memory.

---
 rtl/fetch_controller_if.sv | 29 ++
 rtl/fetch_controller.sv | 110 +++++++++++
 tb/tb_fetch_controller.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_controller_if.sv
// Fetch controller bus: instruction memory port, decode handshake,
// branch redirect and run control.
interface fetch_controller_if;
   logic        Start;
   logic [63:0] Mem_Addr;
   logic [7:0]  Mem_Data;
   logic [31:0] Instruction;
   logic [63:0] Inst_Address;
   logic        Inst_Valid;
   logic        Inst_Ready;
   logic        Branch_Taken;
   logic [63:0] Branch_Target;
   logic        Busy;
   logic        Done;

   modport master (
      input  Start, Mem_Data, Inst_Ready,
      input  Branch_Taken, Branch_Target,
      output Mem_Addr, Instruction, Inst_Address,
      output Inst_Valid, Busy, Done
   );

   modport slave (
      output Start, Mem_Data, Inst_Ready,
      output Branch_Taken, Branch_Target,
      input  Mem_Addr, Instruction, Inst_Address,
      input  Inst_Valid, Busy, Done
   );
endinterface

// File: rtl/fetch_controller.sv
// Byte-serial instruction fetch: assembles 32-bit little-endian words
// from a byte-wide memory and hands them to decode via valid/ready.
module fetch_controller #(
   parameter int unsigned MEM_BYTES = 16,
   parameter logic [63:0] RESET_PC  = 64'd0
) (
   input logic clk,
   input logic reset,
   fetch_controller_if.master bus
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

   state_t      state, state_nx;
   logic [63:0] pc, pc_nx;
   logic [1:0]  cnt, cnt_nx;
   logic [31:0] asm_q, asm_nx;
   logic [31:0] instr_q, instr_nx;
   logic [63:0] iaddr_q, iaddr_nx;
   logic        valid_q, valid_nx;
   logic [63:0] mem_addr;
   logic [63:0] pc_plus4;

   // 65-bit compare so addresses near 2^64 never wrap into range
   function automatic logic in_range(input logic [63:0] a);
      return ({1'b0, a} + 65'd3) <= (65'(MEM_BYTES) - 65'd1);
   endfunction

   assign pc_plus4 = pc + 64'd4;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         pc      <= RESET_PC;
         cnt     <= 2'd0;
         asm_q   <= 32'd0;
         instr_q <= 32'd0;
         iaddr_q <= RESET_PC;
         valid_q <= 1'b0;
      end else begin
         state   <= state_nx;
         pc      <= pc_nx;
         cnt     <= cnt_nx;
         asm_q   <= asm_nx;
         instr_q <= instr_nx;
         iaddr_q <= iaddr_nx;
         valid_q <= valid_nx;
      end
   end

   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      cnt_nx   = cnt;
      asm_nx   = asm_q;
      instr_nx = instr_q;
      iaddr_nx = iaddr_q;
      valid_nx = valid_q;
      mem_addr = pc;
      unique case (state)
         IDLE, DONE: begin
            if (bus.Start) begin
               pc_nx    = RESET_PC;
               cnt_nx   = 2'd0;
               state_nx = in_range(RESET_PC) ? FETCH : DONE;
            end
         end
         FETCH: begin
            mem_addr = pc + 64'(cnt);
            if (bus.Branch_Taken) begin
               pc_nx    = bus.Branch_Target;
               cnt_nx   = 2'd0;
               valid_nx = 1'b0;
               state_nx = in_range(bus.Branch_Target) ? FETCH : DONE;
            end else begin
               asm_nx[8*cnt +: 8] = bus.Mem_Data;
               cnt_nx = cnt + 2'd1;
               if (cnt == 2'd3) begin
                  instr_nx = {bus.Mem_Data, asm_q[23:0]};
                  iaddr_nx = pc;
                  valid_nx = 1'b1;
                  state_nx = HOLD;
               end
            end
         end
         HOLD: begin
            // redirect wins over a same-cycle accept
            if (bus.Branch_Taken) begin
               pc_nx    = bus.Branch_Target;
               cnt_nx   = 2'd0;
               valid_nx = 1'b0;
               state_nx = in_range(bus.Branch_Target) ? FETCH : DONE;
            end else if (bus.Inst_Ready) begin
               valid_nx = 1'b0;
               pc_nx    = pc_plus4;
               state_nx = in_range(pc_plus4) ? FETCH : DONE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign bus.Mem_Addr     = mem_addr;
   assign bus.Instruction  = instr_q;
   assign bus.Inst_Address = iaddr_q;
   assign bus.Inst_Valid   = valid_q;
   assign bus.Busy         = (state == FETCH) || (state == HOLD);
   assign bus.Done         = (state == DONE);

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: per-cycle vector table for the
// straight-line program plus hand sequences for stall/branch/reset.
module tb_fetch_controller;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_fail;

   fetch_controller_if bus();

   fetch_controller #(.MEM_BYTES(16), .RESET_PC(64'd0)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   logic [7:0] mem [16];
   logic [31:0] exp_ins [4];

   assign bus.Mem_Data = (bus.Mem_Addr < 64'd16) ? mem[bus.Mem_Addr[3:0]] : 8'h00;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic        start;
      logic        ready;
      logic [63:0] exp_maddr;
      logic        exp_valid;
      logic [31:0] exp_instr;
      logic [63:0] exp_iaddr;
      logic        exp_busy;
      logic        exp_done;
   } vec_t;

   vec_t tbl [21];

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " instr"}, bus.Instruction, 64'd0);
      chk({tag, " iaddr"}, bus.Inst_Address, 64'd0);
      chk({tag, " valid"}, bus.Inst_Valid, 64'd0);
      chk({tag, " busy"}, bus.Busy, 64'd0);
      chk({tag, " done"}, bus.Done, 64'd0);
      chk({tag, " maddr"}, bus.Mem_Addr, 64'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic wait_valid(input int max, output int n);
      n = 0;
      while (!bus.Inst_Valid && n < max) begin
         step();
         n++;
      end
   endtask

   task automatic run_table(input string tag);
      for (int j = 0; j < 21; j++) begin
         bus.Start      = tbl[j].start;
         bus.Inst_Ready = tbl[j].ready;
         step();
         chk($sformatf("%s v%0d maddr", tag, j), bus.Mem_Addr, tbl[j].exp_maddr);
         chk($sformatf("%s v%0d valid", tag, j), bus.Inst_Valid, 64'(tbl[j].exp_valid));
         chk($sformatf("%s v%0d busy", tag, j), bus.Busy, 64'(tbl[j].exp_busy));
         chk($sformatf("%s v%0d done", tag, j), bus.Done, 64'(tbl[j].exp_done));
         if (tbl[j].exp_valid) begin
            chk($sformatf("%s v%0d instr", tag, j), bus.Instruction, 64'(tbl[j].exp_instr));
            chk($sformatf("%s v%0d iaddr", tag, j), bus.Inst_Address, tbl[j].exp_iaddr);
         end
      end
      bus.Start = 1'b0;
   endtask

   initial begin
      int n;
      int idx;
      n_chk  = 0;
      n_fail = 0;
      mem = '{8'h83, 8'h34, 8'h85, 8'h02, 8'hB3, 8'h84, 8'h9A, 8'h00,
              8'h93, 8'h84, 8'h14, 8'h00, 8'h23, 8'h34, 8'h95, 8'h02};
      exp_ins = '{32'h02853483, 32'h009A84B3, 32'h00148493, 32'h02953423};

      // 4 fetch cycles then one HOLD cycle per word, then DONE
      idx = 0;
      for (int k = 0; k < 4; k++) begin
         for (int b = 0; b < 4; b++) begin
            tbl[idx] = '{start: (k == 0 && b == 0), ready: 1'b1,
                         exp_maddr: 64'(4*k + b), exp_valid: 1'b0,
                         exp_instr: 32'd0, exp_iaddr: 64'd0,
                         exp_busy: 1'b1, exp_done: 1'b0};
            idx++;
         end
         tbl[idx] = '{start: 1'b0, ready: 1'b1, exp_maddr: 64'(4*k),
                      exp_valid: 1'b1, exp_instr: exp_ins[k],
                      exp_iaddr: 64'(4*k), exp_busy: 1'b1, exp_done: 1'b0};
         idx++;
      end
      tbl[20] = '{start: 1'b0, ready: 1'b1, exp_maddr: 64'd16,
                  exp_valid: 1'b0, exp_instr: 32'd0, exp_iaddr: 64'd0,
                  exp_busy: 1'b0, exp_done: 1'b1};

      bus.Start         = 1'b0;
      bus.Inst_Ready    = 1'b0;
      bus.Branch_Taken  = 1'b0;
      bus.Branch_Target = 64'd0;
      reset = 1'b1;
      step();
      step();
      chk_reset("reset");
      reset = 1'b0;

      run_table("run1");
      run_table("run2");

      // decode stall for 10 cycles, then a single-cycle accept
      do_reset();
      bus.Start = 1'b1;
      bus.Inst_Ready = 1'b0;
      step();
      bus.Start = 1'b0;
      wait_valid(10, n);
      chk("stall first latency", 64'(n), 64'd4);
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("stall c%0d instr", i), bus.Instruction, 64'h02853483);
         chk($sformatf("stall c%0d maddr", i), bus.Mem_Addr, 64'd0);
         chk($sformatf("stall c%0d valid", i), bus.Inst_Valid, 64'd1);
      end
      bus.Inst_Ready = 1'b1;
      step();
      bus.Inst_Ready = 1'b0;
      chk("stall accept valid", bus.Inst_Valid, 64'd0);
      chk("stall accept maddr", bus.Mem_Addr, 64'd4);
      wait_valid(10, n);
      chk("stall next latency", 64'(n), 64'd4);
      chk("stall next instr", bus.Instruction, 64'h009A84B3);
      chk("stall next iaddr", bus.Inst_Address, 64'd4);

      // redirect during byte 2 of the first fetch
      do_reset();
      bus.Start = 1'b1;
      bus.Inst_Ready = 1'b1;
      step();
      bus.Start = 1'b0;
      step();
      step();
      bus.Branch_Taken = 1'b1;
      bus.Branch_Target = 64'd12;
      step();
      bus.Branch_Taken = 1'b0;
      chk("br fetch maddr", bus.Mem_Addr, 64'd12);
      chk("br fetch valid", bus.Inst_Valid, 64'd0);
      wait_valid(10, n);
      chk("br fetch latency", 64'(n), 64'd4);
      chk("br fetch instr", bus.Instruction, 64'h02953423);
      chk("br fetch iaddr", bus.Inst_Address, 64'd12);
      step();
      chk("br fetch done", bus.Done, 64'd1);
      chk("br fetch done valid", bus.Inst_Valid, 64'd0);
      chk("br fetch done maddr", bus.Mem_Addr, 64'd16);

      // redirect and accept in the same HOLD cycle
      do_reset();
      bus.Start = 1'b1;
      bus.Inst_Ready = 1'b0;
      step();
      bus.Start = 1'b0;
      wait_valid(10, n);
      chk("br hold first latency", 64'(n), 64'd4);
      bus.Branch_Taken = 1'b1;
      bus.Branch_Target = 64'd4;
      bus.Inst_Ready = 1'b1;
      step();
      bus.Branch_Taken = 1'b0;
      bus.Inst_Ready = 1'b0;
      chk("br hold valid", bus.Inst_Valid, 64'd0);
      chk("br hold maddr", bus.Mem_Addr, 64'd4);
      chk("br hold busy", bus.Busy, 64'd1);
      wait_valid(10, n);
      chk("br hold latency", 64'(n), 64'd4);
      chk("br hold instr", bus.Instruction, 64'h009A84B3);
      chk("br hold iaddr", bus.Inst_Address, 64'd4);
      bus.Branch_Taken = 1'b1;
      bus.Branch_Target = 64'd14;
      bus.Inst_Ready = 1'b1;
      step();
      bus.Branch_Taken = 1'b0;
      bus.Inst_Ready = 1'b0;
      chk("br oob done", bus.Done, 64'd1);
      chk("br oob busy", bus.Busy, 64'd0);
      chk("br oob valid", bus.Inst_Valid, 64'd0);
      chk("br oob maddr", bus.Mem_Addr, 64'd14);

      // reset in the third fetch cycle
      do_reset();
      bus.Start = 1'b1;
      bus.Inst_Ready = 1'b1;
      step();
      bus.Start = 1'b0;
      step();
      step();
      chk("rst mid maddr", bus.Mem_Addr, 64'd2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_reset("rst mid");
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("rst idle c%0d valid", i), bus.Inst_Valid, 64'd0);
         chk($sformatf("rst idle c%0d busy", i), bus.Busy, 64'd0);
      end
      bus.Start = 1'b1;
      step();
      bus.Start = 1'b0;
      wait_valid(10, n);
      chk("rst refetch latency", 64'(n), 64'd4);
      chk("rst refetch instr", bus.Instruction, 64'h02853483);
      chk("rst refetch iaddr", bus.Inst_Address, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
